// File: rtl/display_source_scheduler.sv
// Display/alarm source sequencer: picks gsensor or light view by button, dwell timer or alarm preemption.
// Optional macro BTN_DEBOUNCE_EN adds a stable-high debounce on btn_next.
module display_source_scheduler #(
   parameter int DWELL_CYCLES      = 50_000_000,
   parameter int ALARM_HOLD_CYCLES = 25_000_000,
   parameter int DEBOUNCE_CYCLES   = 1_000_000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       btn_next,
   input  logic       auto_mode,
   input  logic       gsensor_alarm,
   input  logic       light_alarm,
   output logic [1:0] select,
   output logic       buzzer_en,
   output logic       source_changed
);

   localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam int HW = (ALARM_HOLD_CYCLES > 1) ? $clog2(ALARM_HOLD_CYCLES) : 1;

   typedef enum logic [1:0] {NORM_G, NORM_L, ALARM_G, ALARM_L} state_t;

   state_t          state_q, state_d;
   logic            savedL_q, savedL_d;
   logic [DW-1:0]   dwellCnt_q, dwellCnt_d;
   logic [HW-1:0]   holdCnt_q, holdCnt_d;
   logic [1:0]      select_q, select_d;
   logic            buzzer_q, buzzer_d;
   logic            changed_q, changed_d;
   logic            btnEvent;

`ifdef BTN_DEBOUNCE_EN
   localparam int BW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   logic [BW-1:0] debCnt_q, debCnt_d;
   logic          debDone_q, debDone_d;

   // The press fires once when the stable-high run completes; debDone blocks repeats until release.
   always_comb begin
      debCnt_d  = debCnt_q;
      debDone_d = debDone_q;
      btnEvent  = 1'b0;
      if (!btn_next) begin
         debCnt_d  = '0;
         debDone_d = 1'b0;
      end else if (!debDone_q) begin
         if (debCnt_q == BW'(DEBOUNCE_CYCLES - 1)) begin
            btnEvent  = 1'b1;
            debDone_d = 1'b1;
            debCnt_d  = '0;
         end else begin
            debCnt_d = debCnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         debCnt_q  <= '0;
         debDone_q <= 1'b0;
      end else begin
         debCnt_q  <= debCnt_d;
         debDone_q <= debDone_d;
      end
   end
`else
   logic btnPrev_q;

   assign btnEvent = btn_next & ~btnPrev_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) btnPrev_q <= 1'b0;
      else          btnPrev_q <= btn_next;
   end
`endif

   // Next-state logic; counters default to 0 so they only advance where explicitly kept.
   always_comb begin
      state_d    = state_q;
      savedL_d   = savedL_q;
      dwellCnt_d = '0;
      holdCnt_d  = '0;
      case (state_q)
         NORM_G, NORM_L: begin
            if (gsensor_alarm) begin
               state_d  = ALARM_G;
               savedL_d = (state_q == NORM_L);
            end else if (light_alarm) begin
               state_d  = ALARM_L;
               savedL_d = (state_q == NORM_L);
            end else if (btnEvent) begin
               state_d = (state_q == NORM_G) ? NORM_L : NORM_G;
            end else if (auto_mode) begin
               if (dwellCnt_q == DW'(DWELL_CYCLES - 1))
                  state_d = (state_q == NORM_G) ? NORM_L : NORM_G;
               else
                  dwellCnt_d = dwellCnt_q + 1'b1;
            end
         end
         ALARM_G: begin
            if (!gsensor_alarm) begin
               if (holdCnt_q == HW'(ALARM_HOLD_CYCLES - 1)) begin
                  if (light_alarm) state_d = ALARM_L;
                  else             state_d = savedL_q ? NORM_L : NORM_G;
               end else begin
                  holdCnt_d = holdCnt_q + 1'b1;
               end
            end
         end
         ALARM_L: begin
            if (gsensor_alarm) begin
               state_d = ALARM_G;
            end else if (!light_alarm) begin
               if (holdCnt_q == HW'(ALARM_HOLD_CYCLES - 1))
                  state_d = savedL_q ? NORM_L : NORM_G;
               else
                  holdCnt_d = holdCnt_q + 1'b1;
            end
         end
         default: state_d = NORM_G;
      endcase

      select_d  = (state_d == NORM_L || state_d == ALARM_L) ? 2'd1 : 2'd0;
      buzzer_d  = (state_d == ALARM_G || state_d == ALARM_L);
      changed_d = (select_d != select_q);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= NORM_G;
         savedL_q   <= 1'b0;
         dwellCnt_q <= '0;
         holdCnt_q  <= '0;
         select_q   <= 2'd0;
         buzzer_q   <= 1'b0;
         changed_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         savedL_q   <= savedL_d;
         dwellCnt_q <= dwellCnt_d;
         holdCnt_q  <= holdCnt_d;
         select_q   <= select_d;
         buzzer_q   <= buzzer_d;
         changed_q  <= changed_d;
      end
   end

   assign select         = select_q;
   assign buzzer_en      = buzzer_q;
   assign source_changed = changed_q;

endmodule

// File: tb/tb_display_source_scheduler.sv
// Self-checking bench for display_source_scheduler; outputs compared every cycle against a behavioural model.
// Build with +define+BTN_DEBOUNCE_EN to also exercise the debounce scenario.
module tb_display_source_scheduler;

   localparam int DWELL = 8;
   localparam int HOLD  = 4;
   localparam int DEB   = 3;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       btn_next = 1'b0;
   logic       auto_mode = 1'b0;
   logic       gsensor_alarm = 1'b0;
   logic       light_alarm = 1'b0;
   logic [1:0] select;
   logic       buzzer_en;
   logic       source_changed;

   int nCompared = 0;
   int nMismatched = 0;
   int cycleNo = 0;

   // Model state: which normal view is active, which alarm (0 none, 1 g, 2 light) is shown.
   int   mNorm, mAlarm, mDwell, mHold, mPress, mSel;
   bit   mPrevBtn;
   logic [3:0] expOut;

   display_source_scheduler #(
      .DWELL_CYCLES(DWELL),
      .ALARM_HOLD_CYCLES(HOLD),
      .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .btn_next(btn_next),
      .auto_mode(auto_mode),
      .gsensor_alarm(gsensor_alarm),
      .light_alarm(light_alarm),
      .select(select),
      .buzzer_en(buzzer_en),
      .source_changed(source_changed)
   );

   always #5 clk = ~clk;

   task automatic modelReset();
      mNorm = 0; mAlarm = 0; mDwell = 0; mHold = 0; mPress = 0; mSel = 0;
      mPrevBtn = 1'b0;
      expOut = 4'b0000;
   endtask

   // One clock of the reference behaviour, using the inputs present at the edge.
   task automatic modelStep();
      bit ev;
      int newSel;
`ifdef BTN_DEBOUNCE_EN
      if (btn_next) mPress++; else mPress = 0;
      ev = (mPress == DEB);
`else
      ev = btn_next && !mPrevBtn;
`endif
      mPrevBtn = btn_next;
      if (mAlarm == 0) begin
         mHold = 0;
         if (gsensor_alarm) begin
            mAlarm = 1; mDwell = 0;
         end else if (light_alarm) begin
            mAlarm = 2; mDwell = 0;
         end else if (ev) begin
            mNorm = 1 - mNorm; mDwell = 0;
         end else if (auto_mode) begin
            mDwell++;
            if (mDwell == DWELL) begin
               mNorm = 1 - mNorm; mDwell = 0;
            end
         end else begin
            mDwell = 0;
         end
      end else begin
         mDwell = 0;
         if (mAlarm == 2 && gsensor_alarm) begin
            mAlarm = 1; mHold = 0;
         end else if ((mAlarm == 1 && gsensor_alarm) || (mAlarm == 2 && light_alarm)) begin
            mHold = 0;
         end else begin
            mHold++;
            if (mHold == HOLD) begin
               mHold = 0;
               if (mAlarm == 1 && light_alarm) mAlarm = 2;
               else                            mAlarm = 0;
            end
         end
      end
      newSel = (mAlarm == 1) ? 0 : (mAlarm == 2) ? 1 : mNorm;
      expOut = {newSel[1:0], (mAlarm != 0), (newSel != mSel)};
      mSel = newSel;
   endtask

   task automatic cycle();
      @(posedge clk);
      modelStep();
      #1;
      cycleNo++;
   endtask

   task automatic applyStimulus(input bit b, input bit a, input bit g, input bit l);
      btn_next = b; auto_mode = a; gsensor_alarm = g; light_alarm = l;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      applyStimulus(0, 0, 0, 0);
      #3;
      nCompared++;
      if ({select, buzzer_en, source_changed} !== 4'b0000) begin
         nMismatched++;
         $display("[TB] FAIL reset_hold: got %b expected %b", {select, buzzer_en, source_changed}, 4'b0000);
      end
      @(negedge clk);
      reset_n = 1'b1;
      modelReset();
      for (int i = 0; i < 3; i++) begin
         cycle();
         nCompared++;
         if ({select, buzzer_en, source_changed} !== expOut) begin
            nMismatched++;
            $display("[TB] FAIL reset_idle cyc %0d: got %b expected %b", cycleNo, {select, buzzer_en, source_changed}, expOut);
         end
      end
   endtask

   task automatic test_auto_rotate();
      int pulses = 0;
      applyStimulus(0, 1, 0, 0);
      for (int i = 0; i < 17; i++) begin
         cycle();
         pulses += int'(source_changed);
         nCompared++;
         if ({select, buzzer_en, source_changed} !== expOut) begin
            nMismatched++;
            $display("[TB] FAIL auto_rotate cyc %0d: got %b expected %b", cycleNo, {select, buzzer_en, source_changed}, expOut);
         end
      end
      nCompared++;
      if (pulses != 2) begin
         nMismatched++;
         $display("[TB] FAIL auto_pulses: got %0d expected 2", pulses);
      end
      applyStimulus(0, 0, 0, 0);
      cycle();
   endtask

   task automatic test_button();
      int pulses = 0;
      int want;
`ifdef BTN_DEBOUNCE_EN
      want = 1;
`else
      want = 2;
`endif
      for (int i = 0; i < 32; i++) begin
         applyStimulus((i == 10) || (i >= 20 && i < 25), 0, 0, 0);
         cycle();
         pulses += int'(source_changed);
         nCompared++;
         if ({select, buzzer_en, source_changed} !== expOut) begin
            nMismatched++;
            $display("[TB] FAIL button cyc %0d: got %b expected %b", cycleNo, {select, buzzer_en, source_changed}, expOut);
         end
      end
      nCompared++;
      if (pulses != want) begin
         nMismatched++;
         $display("[TB] FAIL button_pulses: got %0d expected %0d", pulses, want);
      end
   endtask

   task automatic test_gsensor_alarm();
      for (int i = 0; i < 6; i++) begin
         applyStimulus(i < 3, 0, 0, 0);
         cycle();
      end
      if (mNorm == 0) begin
         for (int i = 0; i < 6; i++) begin
            applyStimulus(i < 3, 0, 0, 0);
            cycle();
         end
      end
      for (int i = 0; i < 10; i++) begin
         applyStimulus(0, 0, i < 3, 0);
         cycle();
         nCompared++;
         if ({select, buzzer_en, source_changed} !== expOut) begin
            nMismatched++;
            $display("[TB] FAIL g_alarm cyc %0d: got %b expected %b", cycleNo, {select, buzzer_en, source_changed}, expOut);
         end
      end
   endtask

   task automatic test_dual_alarm();
      for (int i = 0; i < 22; i++) begin
         applyStimulus(0, 0, i < 2, i < 12);
         cycle();
         nCompared++;
         if ({select, buzzer_en, source_changed} !== expOut) begin
            nMismatched++;
            $display("[TB] FAIL dual_alarm cyc %0d: got %b expected %b", cycleNo, {select, buzzer_en, source_changed}, expOut);
         end
      end
   endtask

   task automatic test_async_reset();
      applyStimulus(0, 0, 0, 1);
      cycle();
      cycle();
      #2;
      reset_n = 1'b0;
      #1;
      nCompared++;
      if ({select, buzzer_en, source_changed} !== 4'b0000) begin
         nMismatched++;
         $display("[TB] FAIL async_reset: got %b expected %b", {select, buzzer_en, source_changed}, 4'b0000);
      end
      applyStimulus(0, 1, 0, 0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      modelReset();
      for (int i = 0; i < 18; i++) begin
         cycle();
         nCompared++;
         if ({select, buzzer_en, source_changed} !== expOut) begin
            nMismatched++;
            $display("[TB] FAIL post_reset cyc %0d: got %b expected %b", cycleNo, {select, buzzer_en, source_changed}, expOut);
         end
      end
      applyStimulus(0, 0, 0, 0);
      cycle();
   endtask

`ifdef BTN_DEBOUNCE_EN
   task automatic test_debounce();
      int pulses = 0;
      for (int i = 0; i < 12; i++) begin
         applyStimulus((i < 2) || (i >= 5 && i < 8), 0, 0, 0);
         cycle();
         pulses += int'(source_changed);
         nCompared++;
         if ({select, buzzer_en, source_changed} !== expOut) begin
            nMismatched++;
            $display("[TB] FAIL debounce cyc %0d: got %b expected %b", cycleNo, {select, buzzer_en, source_changed}, expOut);
         end
      end
      nCompared++;
      if (pulses != 1) begin
         nMismatched++;
         $display("[TB] FAIL debounce_pulses: got %0d expected 1", pulses);
      end
   endtask
`endif

   task automatic test_random();
      bit a = 1'b0, g = 1'b0, l = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 29) == 0) a = ~a;
         if ($urandom_range(0, 24) == 0) g = ~g;
         if ($urandom_range(0, 19) == 0) l = ~l;
         if (g && $urandom_range(0, 2) == 0) g = 1'b0;
         applyStimulus($urandom_range(0, 5) < 2, a, g, l);
         cycle();
         nCompared++;
         if ({select, buzzer_en, source_changed} !== expOut) begin
            nMismatched++;
            $display("[TB] FAIL random cyc %0d: got %b expected %b", cycleNo, {select, buzzer_en, source_changed}, expOut);
         end
      end
   endtask

   initial begin
      modelReset();
      test_reset();
      test_auto_rotate();
      test_button();
      test_gsensor_alarm();
      test_dual_alarm();
      test_async_reset();
`ifdef BTN_DEBOUNCE_EN
      test_debounce();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
